// File: rtl/brake_current_sampler.sv
// brake_current_sampler: times one SPI current-sense ADC conversion per active PWM edge
module brake_current_sampler #(
  parameter int ADC_BITS  = 12,
  parameter int SCLK_DIV  = 4,
  parameter int QUIET_CYC = 8
) (
  input  logic        SYSCLK,
  input  logic        OPB_RST,
  input  logic        PWM_IN,
  input  logic        POLARITY,
  input  logic        SAMPLE_TRIG,
  input  logic [31:0] SAMPLE_TIME_SET,
  input  logic        OVR_CLR,
  input  logic        ADC_SDO,
  output logic        ADC_CSb,
  output logic        ADC_SCLK,
  output logic [15:0] SAMPLE_DATA,
  output logic        SAMPLE_VALID,
  output logic        BUSY,
  output logic        OVERRUN
);
  typedef enum logic [1:0] {IDLE, DELAY, CONV, QUIET} state_t;
  localparam logic [8:0] PH_HI   = 9'(SCLK_DIV);
  localparam logic [8:0] PH_LAST = 9'(2 * SCLK_DIV - 1);
  state_t state, state_nx;
  logic pwm_d, act_edge, conv_end;
  logic [31:0] cnt;
  logic [8:0] ph;
  logic [3:0] slot;
  logic [ADC_BITS-1:0] sh;
  assign act_edge = POLARITY ? (PWM_IN & ~pwm_d) : (~PWM_IN & pwm_d);
  assign conv_end = (state == CONV) && (slot == 4'hf) && (ph == PH_LAST);
  assign ADC_CSb  = state != CONV;
  assign ADC_SCLK = !(state == CONV && ph < PH_HI);
  assign BUSY     = state != IDLE;
  always_ff @(posedge SYSCLK or posedge OPB_RST) begin
    if (OPB_RST) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (act_edge && SAMPLE_TRIG) ? DELAY : IDLE;
      DELAY:   state_nx = (cnt == SAMPLE_TIME_SET) ? CONV : DELAY;
      CONV:    state_nx = conv_end ? QUIET : CONV;
      default: state_nx = (cnt == 32'(QUIET_CYC - 1)) ? IDLE : QUIET;
    endcase
  end
  // cnt is shared: delay count in DELAY, gap count in QUIET
  always_ff @(posedge SYSCLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      pwm_d        <= 1'b0;
      cnt          <= '0;
      ph           <= '0;
      slot         <= '0;
      sh           <= '0;
      SAMPLE_DATA  <= '0;
      SAMPLE_VALID <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      pwm_d        <= PWM_IN;
      cnt          <= (state == IDLE || state != state_nx) ? '0 : cnt + 32'd1;
      ph           <= (state == CONV && ph != PH_LAST) ? ph + 9'd1 : '0;
      slot         <= (state != CONV) ? '0 : (ph == PH_LAST) ? slot + 4'd1 : slot;
      sh           <= (state == CONV && ph == PH_HI) ? {sh[ADC_BITS-2:0], ADC_SDO} : sh;
      SAMPLE_DATA  <= conv_end ? 16'(sh) : SAMPLE_DATA;
      SAMPLE_VALID <= conv_end;
      OVERRUN      <= (act_edge && state != IDLE) ? 1'b1 : OVR_CLR ? 1'b0 : OVERRUN;
    end
  end
endmodule

// File: tb/tb_brake_current_sampler.sv
// tb_brake_current_sampler: vector table, random transactions and corner sequences with an SPI ADC model
`timescale 1ns/1ps
module tb_brake_current_sampler;
  logic SYSCLK = 0, OPB_RST = 1, PWM_IN = 0, POLARITY = 1, SAMPLE_TRIG = 0, OVR_CLR = 0;
  logic [31:0] SAMPLE_TIME_SET = 0;
  logic ADC_SDO, ADC_CSb, ADC_SCLK, SAMPLE_VALID, BUSY, OVERRUN;
  logic [15:0] SAMPLE_DATA;

  brake_current_sampler dut (
    .SYSCLK(SYSCLK), .OPB_RST(OPB_RST), .PWM_IN(PWM_IN), .POLARITY(POLARITY),
    .SAMPLE_TRIG(SAMPLE_TRIG), .SAMPLE_TIME_SET(SAMPLE_TIME_SET), .OVR_CLR(OVR_CLR),
    .ADC_SDO(ADC_SDO), .ADC_CSb(ADC_CSb), .ADC_SCLK(ADC_SCLK), .SAMPLE_DATA(SAMPLE_DATA),
    .SAMPLE_VALID(SAMPLE_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #6 SYSCLK = ~SYSCLK;

  int cyc = 0;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  // bus monitor and ADC model: a new frame bit is presented after every SCLK fall
  int n_fall = 0, t_fall = 0, n_rise = 0, n_valid = 0, t_valid = 0, busy_cnt = 0, bitn = 0;
  logic [15:0] d_valid = 0, frame = 0;
  logic csb_p = 1, sclk_p = 1;
  assign ADC_SDO = (bitn >= 1 && bitn <= 16) ? frame[4'(16 - bitn)] : 1'b0;
  always @(negedge SYSCLK) begin
    if (csb_p && !ADC_CSb) begin n_fall <= n_fall + 1; t_fall <= cyc; end
    if (!ADC_CSb && !sclk_p && ADC_SCLK) n_rise <= n_rise + 1;
    if (SAMPLE_VALID) begin n_valid <= n_valid + 1; t_valid <= cyc; d_valid <= SAMPLE_DATA; end
    if (BUSY) busy_cnt <= busy_cnt + 1;
    bitn <= ADC_CSb ? 0 : (sclk_p && !ADC_SCLK) ? bitn + 1 : bitn;
    csb_p <= ADC_CSb;
    sclk_p <= ADC_SCLK;
  end

  int n_vec = 0, n_bad = 0;
  localparam int FRAME_CYC = 16 * 2 * 4;
  localparam int QUIET = 8;

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge SYSCLK); #1; end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic setup(bit pol, bit trig, int sts, logic [15:0] fr);
    POLARITY = pol; SAMPLE_TRIG = trig; SAMPLE_TIME_SET = sts; frame = fr;
    tick;
    PWM_IN = ~pol;
    tick(2);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && BUSY; i++) tick;
    tick(2);
  endtask

  task automatic run(input bit pol, input bit trig, input int sts, input logic [15:0] fr,
                     output int fo, output int vo, output int dat, output int pul, output int bz);
    int f0, v0, r0, b0, e;
    setup(pol, trig, sts, fr);
    f0 = n_fall; v0 = n_valid; r0 = n_rise; b0 = busy_cnt;
    PWM_IN = pol; e = cyc;
    tick(3);
    PWM_IN = ~pol;
    for (int i = 0; i < (trig ? sts + 400 : 20) && n_valid == v0; i++) tick;
    wait_idle();
    fo = (n_fall != f0) ? t_fall - e : -1;
    vo = (n_valid != v0) ? t_valid - e : -1;
    dat = int'(d_valid); pul = n_rise - r0; bz = busy_cnt - b0;
  endtask

  typedef struct {bit pol; bit trig; int sts; logic [15:0] fr; int fo; int vo; int dat;} vec_t;
  vec_t tbl[6];

  initial begin
    int fo, vo, dat, pul, bz, f0, v0, e, tv;
    tbl[0] = '{1, 1, 600, 16'h0ABC, 602, 730, 16'h0ABC};
    tbl[1] = '{1, 1, 0,   16'hFABC, 2,   130, 16'h0ABC};
    tbl[2] = '{1, 0, 0,   16'h1234, -1,  -1,  0};
    tbl[3] = '{0, 1, 5,   16'h0555, 7,   135, 16'h0555};
    tbl[4] = '{0, 1, 1,   16'hFFFF, 3,   131, 16'h0FFF};
    tbl[5] = '{1, 1, 3,   16'h5000, 5,   133, 16'h0000};

    tick(3);
    chk("rst_csb", ADC_CSb, 1);
    chk("rst_sclk", ADC_SCLK, 1);
    OPB_RST = 0;
    tick(2);
    chk("rst_data", SAMPLE_DATA, 0);
    chk("rst_valid", SAMPLE_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovr", OVERRUN, 0);

    foreach (tbl[k]) begin
      run(tbl[k].pol, tbl[k].trig, tbl[k].sts, tbl[k].fr, fo, vo, dat, pul, bz);
      chk($sformatf("tbl%0d_csb_fall", k), fo, tbl[k].fo);
      chk($sformatf("tbl%0d_valid", k), vo, tbl[k].vo);
      chk($sformatf("tbl%0d_sclk_pulses", k), pul, tbl[k].trig ? 16 : 0);
      chk($sformatf("tbl%0d_busy_cycles", k), bz, tbl[k].trig ? tbl[k].sts + 1 + FRAME_CYC + QUIET : 0);
      if (tbl[k].trig) chk($sformatf("tbl%0d_data", k), dat, tbl[k].dat);
      chk($sformatf("tbl%0d_ovr", k), OVERRUN, 0);
    end

    // overrun: second edge 50 cycles into the frame
    setup(1, 1, 0, 16'h0321);
    f0 = n_fall; v0 = n_valid;
    PWM_IN = 1; tick(3); PWM_IN = 0;
    for (int i = 0; i < 20 && n_fall == f0; i++) tick;
    for (int i = 0; i < 100 && cyc < t_fall + 50; i++) tick;
    PWM_IN = 1; tick;
    chk("ovr_set", OVERRUN, 1);
    PWM_IN = 0;
    for (int i = 0; i < 400 && n_valid == v0; i++) tick;
    wait_idle(); tick(200);
    chk("ovr_one_frame", n_fall - f0, 1);
    chk("ovr_one_valid", n_valid - v0, 1);
    chk("ovr_data", d_valid, 16'h0321);
    chk("ovr_sticky", OVERRUN, 1);
    OVR_CLR = 1; tick; OVR_CLR = 0;
    chk("ovr_clr", OVERRUN, 0);
    SAMPLE_TIME_SET = 10;
    PWM_IN = 1; tick(3); PWM_IN = 0; tick(2);
    PWM_IN = 1; OVR_CLR = 1; tick; OVR_CLR = 0; PWM_IN = 0;
    chk("ovr_set_wins", OVERRUN, 1);
    wait_idle();
    OVR_CLR = 1; tick; OVR_CLR = 0;

    // edge in last QUIET cycle ignored, edge one cycle after IDLE accepted
    setup(1, 1, 3, 16'h0777);
    f0 = n_fall; v0 = n_valid;
    PWM_IN = 1; tick(3); PWM_IN = 0;
    for (int i = 0; i < 400 && n_valid == v0; i++) tick;
    tv = t_valid;
    for (int i = 0; i < 20 && cyc < tv + QUIET - 1; i++) tick;
    PWM_IN = 1; tick;
    PWM_IN = 0;
    chk("quiet_edge_ovr", OVERRUN, 1);
    tick;
    PWM_IN = 1; e = cyc; tick(3); PWM_IN = 0;
    for (int i = 0; i < 400 && n_valid < v0 + 2; i++) tick;
    wait_idle();
    chk("idle_edge_frames", n_fall - f0, 2);
    chk("idle_edge_csb_fall", t_fall - e, 5);
    chk("idle_edge_data", d_valid, 16'h0777);
    OVR_CLR = 1; tick; OVR_CLR = 0;

    // POLARITY=0: rising edge must not trigger
    setup(0, 0, 0, 16'h0123);
    PWM_IN = 0; tick(2);
    SAMPLE_TRIG = 1; f0 = busy_cnt;
    PWM_IN = 1; tick(20);
    chk("pol0_rise_busy", busy_cnt - f0, 0);
    chk("pol0_rise_csb", ADC_CSb, 1);

    // asynchronous reset in CONV slot 7
    setup(1, 1, 0, 16'h0ABC);
    PWM_IN = 1; e = cyc; tick(3); PWM_IN = 0;
    for (int i = 0; i < 100 && cyc < e + 2 + 7 * 8 + 2; i++) tick;
    chk("pre_rst_csb", ADC_CSb, 0);
    OPB_RST = 1; #1;
    chk("midrst_csb", ADC_CSb, 1);
    chk("midrst_sclk", ADC_SCLK, 1);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_data", SAMPLE_DATA, 0);
    tick(2); OPB_RST = 0; tick(3);
    chk("postrst_busy", BUSY, 0);

    // randomized transactions against the behavioural model
    for (int k = 0; k < 16; k++) begin
      bit pol, trig;
      int sts;
      logic [15:0] fr;
      pol = 1'($urandom); trig = ($urandom_range(0, 3) != 0);
      sts = $urandom_range(0, 40); fr = 16'($urandom);
      run(pol, trig, sts, fr, fo, vo, dat, pul, bz);
      chk($sformatf("rnd%0d_csb_fall", k), fo, trig ? 2 + sts : -1);
      chk($sformatf("rnd%0d_valid", k), vo, trig ? 2 + sts + FRAME_CYC : -1);
      chk($sformatf("rnd%0d_busy_cycles", k), bz, trig ? sts + 1 + FRAME_CYC + QUIET : 0);
      if (trig) chk($sformatf("rnd%0d_data", k), dat, int'(fr) % 4096);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/brake_current_sampler.md
Name: brake_current_sampler

Overview:
- Downstream companion to the brake PWM controller: consumes the brake PWM pulse plus the sample-time and sample-trigger settings, and times one current-sense ADC conversion per PWM pulse.
- Waits a programmable delay after each active pulse edge, runs a 16-bit SPI frame to a 12-bit serial ADC (4 leading zeros + 12 data bits, MSB first), then presents the result with a one-cycle valid strobe.
- Sits between the brake controller register block and the external current ADC; results feed the fault/telemetry register read path.

Parameters:
- ADC_BITS, 12, data bits extracted from the LSBs of the 16-bit frame.
- SCLK_DIV, 4, SYSCLK cycles per SCLK half period; legal range 2..255.
- QUIET_CYC, 8, minimum SYSCLK cycles CSb stays high between frames.

Ports:
- SYSCLK  in  1  80 MHz system clock; all logic on posedge.
- OPB_RST  in  1  asynchronous active-high reset.
- PWM_IN  in  1  brake PWM pulse, SYSCLK-domain.
- POLARITY  in  1  1: active edge is PWM_IN rising; 0: falling.
- SAMPLE_TRIG  in  1  level; 1 arms sampling on every active edge.
- SAMPLE_TIME_SET  in  32  delay in SYSCLK cycles from edge to conversion start.
- OVR_CLR  in  1  single-cycle clear of OVERRUN.
- ADC_SDO  in  1  serial data from ADC.
- ADC_CSb  out  1  ADC chip select, active low.
- ADC_SCLK  out  1  ADC serial clock, idles high.
- SAMPLE_DATA  out  16  zero-extended last result.
- SAMPLE_VALID  out  1  one-cycle strobe when SAMPLE_DATA updates.
- BUSY  out  1  high in any state other than IDLE.
- OVERRUN  out  1  sticky; an active edge arrived while not IDLE.

Behaviour:
- Reset: internal state forced to IDLE. Output reset values: ADC_CSb=1, ADC_SCLK=1, SAMPLE_DATA=0, SAMPLE_VALID=0, BUSY=0, OVERRUN=0. Reset applies immediately, including mid-frame.
- Edge detect: PWM_IN is registered once (pwm_d). The active edge is evaluated in cycle E:
  - POLARITY=1: PWM_IN & ~pwm_d.
  - POLARITY=0: ~PWM_IN & pwm_d.
- States: IDLE, DELAY, CONV, QUIET.
  - IDLE: on an active edge with SAMPLE_TRIG=1, go to DELAY and clear the 32-bit delay counter. An edge with SAMPLE_TRIG=0 is ignored.
  - DELAY: the counter increments each cycle. When it equals SAMPLE_TIME_SET, go to CONV, and ADC_CSb falls in that same cycle. With SAMPLE_TIME_SET=0 this means ADC_CSb falls at E+2. In general ADC_CSb falls at E+2+SAMPLE_TIME_SET.
  - CONV: 16 bit slots, each 2*SCLK_DIV cycles.
    - ADC_SCLK is low for the first SCLK_DIV cycles of a slot and high for the second SCLK_DIV cycles.
    - ADC_SDO is shifted in on the cycle ADC_SCLK goes high, MSB first.
    - After slot 16 completes (128 cycles at default), ADC_CSb=1.
    - In that same cycle, SAMPLE_DATA = {zeros, frame[ADC_BITS-1:0]} and SAMPLE_VALID=1 for exactly one cycle.
    - Then go to QUIET.
  - QUIET: ADC_CSb held high for QUIET_CYC cycles, then IDLE.
- OVERRUN: an active edge seen in DELAY, CONV or QUIET is ignored (no queuing) and sets OVERRUN. OVR_CLR clears it. If set and clear happen in the same cycle, set wins.
- SAMPLE_TRIG dropping mid-operation: the current frame completes normally; no new arm occurs.
- SAMPLE_TIME_SET changing during DELAY: the new value is compared immediately.
  - If the counter is already past the new value, the counter wraps at 2^32 before matching. This is software's responsibility; no guard is provided.
- POLARITY change: takes effect on the next cycle's edge evaluation.
- The upper 4 frame bits are discarded, not checked.

Test Plan:
- Reset, then POLARITY=1, SAMPLE_TRIG=1, SAMPLE_TIME_SET=0x258; raise PWM_IN at cycle E -> ADC_CSb falls at E+602; ADC_SCLK produces 16 low/high pulses of 4+4 cycles; SAMPLE_VALID pulses at E+730.
- ADC model drives frame 0x0ABC -> SAMPLE_DATA=0x0ABC. Frame 0xFABC -> SAMPLE_DATA=0x0ABC.
- SAMPLE_TIME_SET=0 with an edge at E -> ADC_CSb falls at E+2. SAMPLE_TRIG=0 with an edge -> BUSY stays 0 and CSb stays 1.
- Second rising edge at CSb-fall+50 -> OVERRUN=1 and no second frame. Pulse OVR_CLR -> OVERRUN=0. Assert OVR_CLR in the same cycle as a new overrun edge -> OVERRUN=1.
- POLARITY=0: falling edge of PWM_IN triggers and rising edge does not. Assert OPB_RST at CONV slot 7 -> CSb=1, SCLK=1, BUSY=0 immediately, SAMPLE_DATA=0.
- Edge arriving in the last QUIET cycle -> ignored and OVERRUN set. Edge one cycle after the return to IDLE -> accepted.
